pixel_command_queue: RTL and testbench
======================================

// Module: pixel_command_queue
// PURPOSE
//  Host-side command queue that feeds the memory-request port of MemoryManager.
//  Buffers pixel read/write commands (x, y, data) from the host bus in a FIFO and range-checks them.
//  Sequences commands one at a time through the manager's request/complete handshake.
//  Returns read data in command order; the host never stalls on video-slot arbitration.
// PARAMETERS
//  FIFO_DEPTH     8    command entries; power of 2, >= 2
//  SCREEN_WIDTH   320  valid x is 0..SCREEN_WIDTH-1
//  SCREEN_HEIGHT  240  valid y is 0..SCREEN_HEIGHT-1
// PORTS
//  clock               in   1  system clock, same as MemoryManager
//  reset               in   1  synchronous, active-high
//  cmdValid            in   1  host command present
//  cmdReady            out  1  queue can accept; = (fifoCount != FIFO_DEPTH), combinational
//  cmdWrite            in   1  1 = write, 0 = read
//  cmdX                in   9  pixel x
//  cmdY                in   8  pixel y
//  cmdData             in   8  write data; ignored for reads
//  rspValid            out  1  1-cycle pulse: rspData holds read result
//  rspData             out  8  read result, held until next rspValid
//  memoryXCoord        out  9  to MemoryManager; stable while a request is high
//  memoryYCoord        out  8  to MemoryManager; stable while a request is high
//  memoryWriteData     out  8  to MemoryManager; stable while memoryWriteRequest is high
//  memoryReadRequest   out  1  level request, held until memoryReadComplete
//  memoryWriteRequest  out  1  level request, held until memoryWriteComplete
//  memoryReadData      in   8  valid in the cycle memoryReadComplete is high
//  memoryReadComplete  in   1  1-cycle pulse from MemoryManager
//  memoryWriteComplete in   1  1-cycle pulse from MemoryManager
//  fifoCount           out  $clog2(FIFO_DEPTH)+1  current occupancy
//  dropCount           out  8  out-of-range commands seen; saturates at 255
//  busy                out  1  (state != IDLE) || (fifoCount != 0)
// BEHAVIOUR
//  Reset:
//   - All outputs 0, except cmdReady = 1.
//   - FIFO emptied, FSM to IDLE.
//   - An in-flight request is abandoned; MemoryManager shares the same reset.
//  Push (cmdValid && cmdReady):
//   - Stores {write, x, y, data, oor}; oor = (cmdX >= SCREEN_WIDTH) || (cmdY >= SCREEN_HEIGHT).
//   - oor also increments dropCount, saturating at 255.
//  Full:
//   - cmdReady is low at fifoCount == FIFO_DEPTH, even if a pop occurs in the same cycle (no lookahead).
//   - Push and pop in the same cycle leave fifoCount unchanged.
//   - Read/write pointers wrap modulo FIFO_DEPTH.
//  FSM states IDLE, WAIT_WR, WAIT_RD, SKIP:
//   - IDLE with FIFO non-empty: pop head.
//     - oor entry -> SKIP.
//     - Otherwise load coord/data registers and raise the matching request at the same edge -> WAIT_WR / WAIT_RD.
//   - WAIT_WR: hold everything; on memoryWriteComplete -> memoryWriteRequest <= 0, go to IDLE.
//   - WAIT_RD: on memoryReadComplete -> memoryReadRequest <= 0, rspData <= memoryReadData, rspValid <= 1, go to IDLE.
//   - SKIP: oor read -> rspValid <= 1, rspData <= 0x00; oor write -> nothing. Go to IDLE. No memory request issued.
//   - IDLE with FIFO empty: stay.
//  Handshake rules:
//   - The request drops at the edge after the complete pulse is seen.
//   - The IDLE cycle guarantees >= 1 low cycle between consecutive requests.
//   - Only one request is ever high; read and write requests are never high together.
//   - A complete pulse that does not match the active request type is ignored.
//  Latency:
//   - Push to request high is 2 cycles with an empty FIFO and IDLE (push edge, then pop edge).
//   - Request to complete is set by MemoryManager: 4-6 cycles.
//  Ordering: responses return in command order; oor reads keep their slot in that order.
//  Coords map to MemoryManager address {y, x}; no arithmetic in this block.
// TESTING  (bench: this block + MemoryManager + async SRAM model)
//  1. Write (10,20,0xAB):
//     -> memoryWriteRequest high for one transaction with X=10, Y=20, data=0xAB held.
//     -> SRAM[{8'd20,9'd10}] == 0xAB; fifoCount returns to 0.
//  2. Write (5,5,0x3C), then read (5,5) back-to-back:
//     -> exactly one rspValid pulse, rspData = 0x3C.
//     -> Requests never overlap and are separated by >= 1 low cycle.
//  3. Push 9 writes on consecutive cycles while the first is pending:
//     -> cmdReady low once fifoCount = 8; the 9th is held until ready.
//     -> All 9 land in SRAM in order with data 0..8.
//  4. Write (320,0), write (0,240), read (319,240):
//     -> No memory request; dropCount = 3.
//     -> One rspValid with rspData = 0x00, in order behind earlier queued reads.
//  5. Reset asserted during WAIT_RD:
//     -> Next cycle: requests 0, rspValid 0, fifoCount 0, dropCount 0, cmdReady 1.
//     -> No rspValid pulse after reset deasserts.
//  6. 300 out-of-range writes -> dropCount saturates at 255 and does not wrap.

Source files
------------

// File: rtl/pixel_command_queue.sv
// Host-side pixel command FIFO that range-checks commands and sequences them one at
// a time through MemoryManager's level-request / complete-pulse handshake.
module pixel_command_queue #(
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned SCREEN_WIDTH  = 320,
    parameter int unsigned SCREEN_HEIGHT = 240
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          cmdValid,
    output logic                          cmdReady,
    input  logic                          cmdWrite,
    input  logic [8:0]                    cmdX,
    input  logic [7:0]                    cmdY,
    input  logic [7:0]                    cmdData,
    output logic                          rspValid,
    output logic [7:0]                    rspData,
    output logic [8:0]                    memoryXCoord,
    output logic [7:0]                    memoryYCoord,
    output logic [7:0]                    memoryWriteData,
    output logic                          memoryReadRequest,
    output logic                          memoryWriteRequest,
    input  logic [7:0]                    memoryReadData,
    input  logic                          memoryReadComplete,
    input  logic                          memoryWriteComplete,
    output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
    output logic [7:0]                    dropCount,
    output logic                          busy
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic       write;
        logic [8:0] x;
        logic [7:0] y;
        logic [7:0] data;
        logic       oor;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_WR = 2'd1,
        WAIT_RD = 2'd2,
        SKIP    = 2'd3
    } state_t;

    cmd_t             fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       drop_q, drop_d;

    state_t           state_q, state_d;
    logic             rd_req_q, rd_req_d;
    logic             wr_req_q, wr_req_d;
    logic [8:0]       x_q, x_d;
    logic [7:0]       y_q, y_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             cur_write_q, cur_write_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_data_q, rsp_data_d;

    cmd_t             push_entry;
    cmd_t             head;
    logic             push;
    logic             pop;

    // No lookahead: a pop in the same cycle does not reopen a full queue.
    assign cmdReady = (count_q != CNT_W'(FIFO_DEPTH));
    assign push     = cmdValid && cmdReady;
    assign pop      = (state_q == IDLE) && (count_q != '0);
    assign head     = fifo_q[rd_ptr_q];

    always_comb begin
        push_entry       = '0;
        push_entry.write = cmdWrite;
        push_entry.x     = cmdX;
        push_entry.y     = cmdY;
        push_entry.data  = cmdData;
        push_entry.oor   = (32'(cmdX) >= SCREEN_WIDTH) || (32'(cmdY) >= SCREEN_HEIGHT);
    end

    // Storage needs no reset; the pointers and count define which entries are live.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= push_entry;
        end
    end

    // Pointer, occupancy and drop-counter next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (push && push_entry.oor && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    // Command sequencer: one request in flight, IDLE between transactions.
    always_comb begin
        state_d     = state_q;
        rd_req_d    = rd_req_q;
        wr_req_d    = wr_req_q;
        x_d         = x_q;
        y_d         = y_q;
        wdata_d     = wdata_q;
        cur_write_d = cur_write_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    cur_write_d = head.write;
                    if (head.oor) begin
                        state_d = SKIP;
                    end else begin
                        x_d     = head.x;
                        y_d     = head.y;
                        wdata_d = head.data;
                        if (head.write) begin
                            wr_req_d = 1'b1;
                            state_d  = WAIT_WR;
                        end else begin
                            rd_req_d = 1'b1;
                            state_d  = WAIT_RD;
                        end
                    end
                end
            end
            WAIT_WR: begin
                if (memoryWriteComplete) begin
                    wr_req_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            WAIT_RD: begin
                if (memoryReadComplete) begin
                    rd_req_d    = 1'b0;
                    rsp_data_d  = memoryReadData;
                    rsp_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            SKIP: begin
                // Out-of-range reads still answer so response order is preserved.
                if (!cur_write_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = 8'h00;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            drop_q      <= '0;
            state_q     <= IDLE;
            rd_req_q    <= 1'b0;
            wr_req_q    <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            wdata_q     <= '0;
            cur_write_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            drop_q      <= drop_d;
            state_q     <= state_d;
            rd_req_q    <= rd_req_d;
            wr_req_q    <= wr_req_d;
            x_q         <= x_d;
            y_q         <= y_d;
            wdata_q     <= wdata_d;
            cur_write_q <= cur_write_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rspValid           = rsp_valid_q;
    assign rspData            = rsp_data_q;
    assign memoryXCoord       = x_q;
    assign memoryYCoord       = y_q;
    assign memoryWriteData    = wdata_q;
    assign memoryReadRequest  = rd_req_q;
    assign memoryWriteRequest = wr_req_q;
    assign fifoCount          = count_q;
    assign dropCount          = drop_q;
    assign busy               = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_pixel_command_queue.sv
// Bench for pixel_command_queue: behavioural MemoryManager/SRAM responder, a
// command-level reference model, a directed vector table and random traffic.
`timescale 1ns/1ps
module tb_pixel_command_queue;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [7:0] d;
    } wr_t;

    typedef struct {
        logic       w;
        logic [8:0] x;
        logic [7:0] y;
        logic [7:0] d;
        logic       has_rsp;
        logic [7:0] rsp;
        logic [7:0] drop;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       cmdValid, cmdReady, cmdWrite;
    logic [8:0] cmdX;
    logic [7:0] cmdY, cmdData;
    logic       rspValid;
    logic [7:0] rspData;
    logic [8:0] memoryXCoord;
    logic [7:0] memoryYCoord, memoryWriteData;
    logic       memoryReadRequest, memoryWriteRequest;
    logic [7:0] memoryReadData;
    logic       memoryReadComplete, memoryWriteComplete;
    logic [3:0] fifoCount;
    logic [7:0] dropCount;
    logic       busy;

    always #5 clock = ~clock;

    pixel_command_queue #(.FIFO_DEPTH(8), .SCREEN_WIDTH(320), .SCREEN_HEIGHT(240)) dut (
        .clock(clock), .reset(reset),
        .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdWrite(cmdWrite),
        .cmdX(cmdX), .cmdY(cmdY), .cmdData(cmdData),
        .rspValid(rspValid), .rspData(rspData),
        .memoryXCoord(memoryXCoord), .memoryYCoord(memoryYCoord),
        .memoryWriteData(memoryWriteData),
        .memoryReadRequest(memoryReadRequest), .memoryWriteRequest(memoryWriteRequest),
        .memoryReadData(memoryReadData),
        .memoryReadComplete(memoryReadComplete), .memoryWriteComplete(memoryWriteComplete),
        .fifoCount(fifoCount), .dropCount(dropCount), .busy(busy)
    );

    // Shared between processes: each variable has exactly one writer.
    logic       hold;
    int         wrong_cnt;
    logic [7:0] sram [0:131071];
    wr_t        act_wr[$];
    logic [7:0] act_rsp[$];
    int         resp_err;
    int         mon_err;

    wr_t        exp_wr[$];
    logic [7:0] exp_rsp[$];
    logic [7:0] mm [int];
    int         drop_m;
    int         wr_chk, rsp_chk;
    int         tests, fails;

    function automatic logic [7:0] init_val(input logic [16:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    // MemoryManager stand-in: 4-6 cycle latency, protocol and stability checks.
    initial begin : responder
        logic pending, is_wr, just_done;
        logic [8:0] cx;
        logic [7:0] cy, cd;
        int cnt, seen;
        pending = 1'b0; is_wr = 1'b0; just_done = 1'b0;
        cx = '0; cy = '0; cd = '0; cnt = 0; seen = 0; resp_err = 0;
        memoryReadComplete = 1'b0; memoryWriteComplete = 1'b0; memoryReadData = 8'h00;
        for (int a = 0; a < 131072; a++) sram[a] = init_val(17'(a));
        forever begin
            @(negedge clock);
            memoryReadComplete  = 1'b0;
            memoryWriteComplete = 1'b0;
            if (reset) begin
                pending = 1'b0; just_done = 1'b0; seen = wrong_cnt;
            end else begin
                if (memoryReadRequest && memoryWriteRequest) begin
                    resp_err++; $display("[TB] protocol: both requests high at %0t", $time);
                end
                if (just_done && (memoryReadRequest || memoryWriteRequest)) begin
                    resp_err++; $display("[TB] protocol: request not dropped after complete at %0t", $time);
                end
                just_done = 1'b0;
                if (!pending) begin
                    if (memoryReadRequest || memoryWriteRequest) begin
                        pending = 1'b1; is_wr = memoryWriteRequest;
                        cx = memoryXCoord; cy = memoryYCoord; cd = memoryWriteData;
                        cnt = $urandom_range(2, 4);
                    end
                end else begin
                    if (memoryXCoord !== cx || memoryYCoord !== cy ||
                        (is_wr && memoryWriteData !== cd) ||
                        (is_wr ? !memoryWriteRequest : !memoryReadRequest)) begin
                        resp_err++; $display("[TB] protocol: request fields changed at %0t", $time);
                    end
                    if (seen != wrong_cnt) begin
                        seen++;
                        if (is_wr) begin
                            memoryReadComplete = 1'b1; memoryReadData = 8'hEE;
                        end else begin
                            memoryWriteComplete = 1'b1;
                        end
                    end else if (!hold) begin
                        if (cnt == 0) begin
                            if (is_wr) begin
                                sram[{cy, cx}] = cd;
                                act_wr.push_back({cx, cy, cd});
                                memoryWriteComplete = 1'b1;
                            end else begin
                                memoryReadData = sram[{cy, cx}];
                                memoryReadComplete = 1'b1;
                            end
                            pending = 1'b0; just_done = 1'b1;
                        end else begin
                            cnt--;
                        end
                    end
                end
            end
        end
    end

    // Response logger; rspValid must be a single-cycle pulse.
    initial begin : monitor
        logic prev;
        prev = 1'b0; mon_err = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev = 1'b0;
            end else begin
                if (rspValid) begin
                    act_rsp.push_back(rspData);
                    if (prev) mon_err++;
                end
                prev = rspValid;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic w, input logic [8:0] x, input logic [7:0] y, input logic [7:0] d);
        int guard;
        int a;
        @(negedge clock);
        cmdValid = 1'b1; cmdWrite = w; cmdX = x; cmdY = y; cmdData = d;
        guard = 0;
        while (!cmdReady && guard < 500) begin
            @(negedge clock);
            guard++;
        end
        if (!cmdReady) begin
            tests++; fails++;
            $display("FAIL push_timeout: got cmdReady=0 for %0d cycles, required 1", guard);
            cmdValid = 1'b0;
        end else begin
            @(posedge clock);
            #1 cmdValid = 1'b0;
            if (int'(x) >= 320 || int'(y) >= 240) begin
                if (drop_m < 255) drop_m++;
                if (!w) exp_rsp.push_back(8'h00);
            end else begin
                a = int'({y, x});
                if (w) begin
                    mm[a] = d;
                    exp_wr.push_back({x, y, d});
                end else begin
                    exp_rsp.push_back(mm.exists(a) ? mm[a] : init_val(17'(a)));
                end
            end
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        @(negedge clock);
        while ((busy || cmdValid) && g < 3000) begin
            @(negedge clock);
            g++;
        end
        chk("drain_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clock);
    endtask

    task automatic check_logs(input string tag);
        chk({tag, "_wr_count"}, 32'(act_wr.size()), 32'(exp_wr.size()));
        chk({tag, "_rsp_count"}, 32'(act_rsp.size()), 32'(exp_rsp.size()));
        for (int i = wr_chk; i < exp_wr.size() && i < act_wr.size(); i++)
            chk({tag, "_wr_entry"}, 32'(act_wr[i]), 32'(exp_wr[i]));
        for (int i = rsp_chk; i < exp_rsp.size() && i < act_rsp.size(); i++)
            chk({tag, "_rsp_data"}, 32'(act_rsp[i]), 32'(exp_rsp[i]));
        wr_chk  = exp_wr.size();
        rsp_chk = exp_rsp.size();
        chk({tag, "_drop"}, 32'(dropCount), 32'(drop_m));
        chk({tag, "_fifo_empty"}, 32'(fifoCount), 32'd0);
        chk({tag, "_protocol"}, 32'(resp_err), 32'd0);
        chk({tag, "_rsp_pulse"}, 32'(mon_err), 32'd0);
    endtask

    task automatic wait_req(input logic want_wr);
        int g;
        g = 0;
        while (!(want_wr ? memoryWriteRequest : memoryReadRequest) && g < 50) begin
            @(negedge clock);
            g++;
        end
        chk("wait_request", 32'(want_wr ? memoryWriteRequest : memoryReadRequest), 32'd1);
    endtask

    initial begin : main
        vec_t vt [12];
        int n;
        logic w;
        logic [8:0] x;
        logic [7:0] y;

        vt[0]  = '{1'b1, 9'd10,  8'd20,  8'hAB, 1'b0, 8'h00, 8'd0};
        vt[1]  = '{1'b1, 9'd5,   8'd5,   8'h3C, 1'b0, 8'h00, 8'd0};
        vt[2]  = '{1'b0, 9'd5,   8'd5,   8'h00, 1'b1, 8'h3C, 8'd0};
        vt[3]  = '{1'b1, 9'd320, 8'd0,   8'h11, 1'b0, 8'h00, 8'd1};
        vt[4]  = '{1'b1, 9'd0,   8'd240, 8'h22, 1'b0, 8'h00, 8'd2};
        vt[5]  = '{1'b0, 9'd319, 8'd240, 8'h00, 1'b1, 8'h00, 8'd3};
        vt[6]  = '{1'b0, 9'd10,  8'd20,  8'h00, 1'b1, 8'hAB, 8'd3};
        vt[7]  = '{1'b1, 9'd319, 8'd239, 8'h77, 1'b0, 8'h00, 8'd3};
        vt[8]  = '{1'b0, 9'd319, 8'd239, 8'h00, 1'b1, 8'h77, 8'd3};
        vt[9]  = '{1'b0, 9'd0,   8'd0,   8'h00, 1'b1, 8'h5A, 8'd3};
        vt[10] = '{1'b1, 9'd511, 8'd255, 8'h01, 1'b0, 8'h00, 8'd4};
        vt[11] = '{1'b0, 9'd320, 8'd0,   8'h00, 1'b1, 8'h00, 8'd5};

        tests = 0; fails = 0; drop_m = 0; wr_chk = 0; rsp_chk = 0;
        hold = 1'b0; wrong_cnt = 0;
        reset = 1'b1; cmdValid = 1'b0; cmdWrite = 1'b0; cmdX = '0; cmdY = '0; cmdData = '0;
        repeat (3) @(negedge clock);
        chk("reset_rspValid", 32'(rspValid), 32'd0);
        chk("reset_requests", 32'({memoryReadRequest, memoryWriteRequest}), 32'd0);
        chk("reset_fifoCount", 32'(fifoCount), 32'd0);
        chk("reset_dropCount", 32'(dropCount), 32'd0);
        chk("reset_cmdReady", 32'(cmdReady), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        // Directed vectors, one command at a time.
        for (int i = 0; i < 12; i++) begin
            n = act_rsp.size();
            push(vt[i].w, vt[i].x, vt[i].y, vt[i].d);
            drain();
            chk("vec_drop", 32'(dropCount), 32'(vt[i].drop));
            chk("vec_rsp_count", 32'(act_rsp.size()), 32'(n + int'(vt[i].has_rsp)));
            if (vt[i].has_rsp && act_rsp.size() > n)
                chk("vec_rsp_data", 32'(act_rsp[act_rsp.size() - 1]), 32'(vt[i].rsp));
        end
        chk("sram_10_20", 32'(sram[{8'd20, 9'd10}]), 32'h0000_00AB);
        chk("sram_319_239", 32'(sram[{8'd239, 9'd319}]), 32'h0000_0077);
        chk("sram_oor_x_untouched", 32'(sram[17'd320]), 32'h0000_001A);
        chk("sram_oor_y_untouched", 32'(sram[{8'd240, 9'd0}]), 32'h0000_005A);
        check_logs("table");

        // Push-to-request latency from an idle, empty queue.
        push(1'b1, 9'd7, 8'd7, 8'h42);
        @(negedge clock);
        chk("lat_count_after_push", 32'(fifoCount), 32'd1);
        chk("lat_no_req_yet", 32'(memoryWriteRequest), 32'd0);
        chk("lat_busy", 32'(busy), 32'd1);
        @(negedge clock);
        chk("lat_req_high", 32'(memoryWriteRequest), 32'd1);
        chk("lat_rd_req_low", 32'(memoryReadRequest), 32'd0);
        chk("lat_coords", 32'({memoryYCoord, memoryXCoord}), 32'({8'd7, 9'd7}));
        chk("lat_wdata", 32'(memoryWriteData), 32'h0000_0042);
        chk("lat_count_after_pop", 32'(fifoCount), 32'd0);
        drain();
        check_logs("latency");

        // Back-to-back commands; the out-of-range read keeps its slot.
        n = act_rsp.size();
        push(1'b1, 9'd6, 8'd6, 8'hC3);
        push(1'b0, 9'd6, 8'd6, 8'h00);
        push(1'b0, 9'd400, 8'd3, 8'h00);
        push(1'b1, 9'd320, 8'd0, 8'h55);
        push(1'b0, 9'd10, 8'd20, 8'h00);
        drain();
        chk("order_count", 32'(act_rsp.size()), 32'(n + 3));
        if (act_rsp.size() >= n + 3) begin
            chk("order_rsp0", 32'(act_rsp[n]), 32'h0000_00C3);
            chk("order_rsp1", 32'(act_rsp[n + 1]), 32'h0000_0000);
            chk("order_rsp2", 32'(act_rsp[n + 2]), 32'h0000_00AB);
        end
        check_logs("order");

        // Fill the queue while the first write is held pending.
        hold = 1'b1;
        for (int k = 0; k < 9; k++) push(1'b1, 9'(k), 8'd50, 8'(k));
        @(negedge clock);
        chk("full_count", 32'(fifoCount), 32'd8);
        chk("full_cmdReady", 32'(cmdReady), 32'd0);
        cmdValid = 1'b1; cmdWrite = 1'b1; cmdX = 9'd9; cmdY = 8'd50; cmdData = 8'd9;
        repeat (5) @(negedge clock);
        chk("full_held_count", 32'(fifoCount), 32'd8);
        chk("full_held_ready", 32'(cmdReady), 32'd0);
        cmdValid = 1'b0;
        hold = 1'b0;
        push(1'b1, 9'd9, 8'd50, 8'd9);
        drain();
        for (int k = 0; k < 10; k++) chk("full_sram", 32'(sram[{8'd50, 9'(k)}]), 32'(k));
        check_logs("full");

        // Complete pulses of the wrong type are ignored.
        hold = 1'b1;
        push(1'b1, 9'd2, 8'd2, 8'h99);
        wait_req(1'b1);
        n = act_rsp.size();
        wrong_cnt++;
        repeat (4) @(negedge clock);
        chk("wrong_wr_still_req", 32'(memoryWriteRequest), 32'd1);
        chk("wrong_wr_no_rsp", 32'(act_rsp.size()), 32'(n));
        hold = 1'b0;
        drain();
        hold = 1'b1;
        push(1'b0, 9'd2, 8'd2, 8'h00);
        wait_req(1'b0);
        wrong_cnt++;
        repeat (4) @(negedge clock);
        chk("wrong_rd_still_req", 32'(memoryReadRequest), 32'd1);
        chk("wrong_rd_no_rsp", 32'(act_rsp.size()), 32'(n));
        hold = 1'b0;
        drain();
        check_logs("wrong");

        // Reset while a read is outstanding.
        hold = 1'b1;
        push(1'b0, 9'd3, 8'd3, 8'h00);
        wait_req(1'b0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_requests", 32'({memoryReadRequest, memoryWriteRequest}), 32'd0);
        chk("rst_rspValid", 32'(rspValid), 32'd0);
        chk("rst_fifoCount", 32'(fifoCount), 32'd0);
        chk("rst_dropCount", 32'(dropCount), 32'd0);
        chk("rst_cmdReady", 32'(cmdReady), 32'd1);
        reset = 1'b0;
        void'(exp_rsp.pop_back());
        drop_m = 0;
        hold = 1'b0;
        n = act_rsp.size();
        repeat (12) @(negedge clock);
        chk("rst_no_late_rsp", 32'(act_rsp.size()), 32'(n));
        chk("rst_idle", 32'(busy), 32'd0);
        check_logs("reset");

        // dropCount saturation.
        for (int k = 0; k < 300; k++) begin
            push(1'b1, 9'd400, 8'd0, 8'h00);
            if (k == 99) chk("sat_drop_100", 32'(dropCount), 32'd100);
        end
        drain();
        chk("sat_drop_255", 32'(dropCount), 32'd255);
        check_logs("saturate");

        // Random traffic against the command-level model.
        for (int i = 0; i < 400; i++) begin
            w = 1'($urandom_range(0, 1));
            x = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(316, 330)) : 9'($urandom_range(0, 15));
            y = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(236, 245)) : 8'($urandom_range(0, 7));
            push(w, x, y, 8'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 8)) @(negedge clock);
        end
        drain();
        check_logs("random");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
